echo_req_fifo: RTL and testbench
================================

# echo_req_fifo

Request buffer directly upstream of the Echo responder. It accepts 32-bit request words from the software-facing request port and holds them in a small circular queue. It presents them through `first`/`deq` guarded methods, which the responder's `rule_respond` consumes in the same cycle it calls the indication. Every method uses the codebase's `__ENA`/`__RDY` guarded-method handshake.

## Interface
Parameters:
- `WIDTH`, 32: request word width.
- `DEPTH`, 4: number of entries; must be a power of two, ≥2.

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `nRST` in 1: reset is asynchronous and active-low.
- `enq__ENA` in 1: enqueue strobe; legal only while `enq__RDY`=1.
- `enq_v` in WIDTH: word to enqueue, sampled when `enq__ENA`=1.
- `enq__RDY` out 1: queue not full and not in reset.
- `deq__ENA` in 1: dequeue strobe; legal only while `deq__RDY`=1.
- `deq__RDY` out 1: queue not empty.
- `first` out WIDTH: head entry; valid only while `first__RDY`=1.
- `first__RDY` out 1: identical to `deq__RDY`.
- `count` out clog2(DEPTH+1): current occupancy.
- `err` out 1: sticky protocol-violation flag.

## Operation
- Storage: DEPTH×WIDTH register array, no reset on data contents.
- Write pointer and read pointer are each clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: the low bits are equal and the MSBs differ.
- `enq__RDY` = nRST & !full.
- `deq__RDY` = `first__RDY` = !empty.
- `first` = mem[rd_ptr low bits], combinational from registered state. When empty, `first` holds the last stale entry. Checkers must not compare it.
- Enqueue with `enq__ENA`=1 and `enq__RDY`=1:
  - mem[wr] ← `enq_v`.
  - wr_ptr increments modulo 2·DEPTH.
  - count increments.
- Dequeue with `deq__ENA`=1 and `deq__RDY`=1:
  - rd_ptr increments modulo 2·DEPTH.
  - count decrements.
- Simultaneous legal enq and deq: both pointers advance and count is unchanged. At empty only enq is legal. At full only deq is legal. There is no bypass of a word enqueued this cycle and no pipelined enq-when-full.
- Illegal strobes:
  - `enq__ENA`=1 with `enq__RDY`=0: ignored; no state change except `err`←1.
  - `deq__ENA`=1 with `deq__RDY`=0: ignored; no state change except `err`←1.
- `err` clears only on reset.

## Timing
- Reset (nRST low, asynchronous):
  - Pointers, count and `err` clear to 0 immediately, without waiting for a clock edge.
  - `enq__RDY`=0, `deq__RDY`=`first__RDY`=0, `count`=0, `err`=0.
- Reset mid-operation: all queued words are discarded and `first__RDY` drops in the same cycle. After deassertion, `enq__RDY`=1 from the first cycle out of reset.
- Enqueue latency: a word enqueued at edge N is visible on `first`, with `first__RDY`=1, during cycle N+1.
- Dequeue: after edge N, `first` presents the next entry in cycle N+1, or `first__RDY`=0 if the queue emptied.
- All outputs are functions of registered state plus `nRST` only, so there are no combinational paths from `enq__ENA`/`deq__ENA` to any `__RDY`. `rule_respond` may therefore assert `deq__ENA` the same cycle it samples `first` without forming a loop.
- Wrap-around: after 2·DEPTH net operations the pointers return to their original values with no discontinuity in ordering.

## Structure
- Shared package `echo_pkg`:
  - `ECHO_WIDTH`=32.
  - typedef `echo_word_t` (logic [ECHO_WIDTH-1:0]).
  - `ECHO_REQ_DEPTH`=4.
- Both the responder and this block import the package.
- Single module; the pointer/count logic is about 40 lines and the storage is an inline array. No sub-module is required.
- Assertions are bound externally:
  - no `enq__ENA` while `!enq__RDY`;
  - no `deq__ENA` while `!deq__RDY`;
  - `count` ≤ DEPTH.

## Test plan
- Reset then single word: enq 0x0000_00A5 at cycle 2 → `first__RDY`=1 and `first`=0xA5 at cycle 3, `count`=1. Deq at cycle 3 → `first__RDY`=0 and `count`=0 at cycle 4.
- Fill to full: enq 1,2,3,4 on consecutive cycles → `enq__RDY`=0 and `count`=4. An extra enq of 5 → `err`=1, and the drained queue yields exactly 1,2,3,4.
- Simultaneous enq/deq at count=2 for 10 cycles with incrementing data → `count` stays 2, output order is strictly FIFO, and the pointers wrap at least twice.
- Deq on empty: `deq__ENA`=1 with `deq__RDY`=0 → `count` stays 0, pointers unchanged, `err`=1.
- Asynchronous reset mid-stream: with 3 words queued, assert nRST between clock edges → `first__RDY`, `count` and `err` go to 0 before the next edge. After release, enq 0x77 → `first`=0x77.
- Back-to-back with the Echo responder model: 100 random words with random enq gaps and deq asserted whenever `deq__RDY` → the indication stream equals the input stream and `err`=0 throughout.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared definitions for the Echo request path: word type and default queue depth.
package echo_pkg;

    localparam int ECHO_WIDTH     = 32;
    localparam int ECHO_REQ_DEPTH = 4;

    typedef logic [ECHO_WIDTH-1:0] echo_word_t;

endpackage : echo_pkg

// File: rtl/echo_req_fifo.sv
// Circular request queue feeding the Echo responder through guarded first/deq methods.
// Every output is derived from registered state and nRST, never from the strobes.
module echo_req_fifo
    import echo_pkg::*;
#(
    parameter int WIDTH = ECHO_WIDTH,
    parameter int DEPTH = ECHO_REQ_DEPTH
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           enq__ENA,
    input  logic [WIDTH-1:0]               enq_v,
    output logic                           enq__RDY,
    input  logic                           deq__ENA,
    output logic                           deq__RDY,
    output logic [WIDTH-1:0]               first,
    output logic                           first__RDY,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic empty, full, enq_ok, deq_ok, do_enq, do_deq;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        enq_ok = nRST & ~full;
        deq_ok = ~empty;
        do_enq = enq__ENA & enq_ok;
        do_deq = deq__ENA & deq_ok;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_enq) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_deq) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q | (enq__ENA & ~enq_ok) | (deq__ENA & ~deq_ok);
    end

    always_comb begin
        mem_d = mem_q;
        if (do_enq) mem_d[wr_ptr_q[AW-1:0]] = enq_v;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage carries no reset; stale contents are hidden behind first__RDY.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_comb begin
        enq__RDY   = enq_ok;
        deq__RDY   = deq_ok;
        first__RDY = deq_ok;
        first      = mem_q[rd_ptr_q[AW-1:0]];
        count      = count_q;
        err        = err_q;
    end

endmodule : echo_req_fifo

// File: tb/tb_echo_req_fifo.sv
// Directed bench for echo_req_fifo, ending with a randomised responder-style stream.
`timescale 1ns/1ps
module tb_echo_req_fifo;

    logic        CLK;
    logic        nRST;
    logic        enq__ENA;
    logic [31:0] enq_v;
    logic        enq__RDY;
    logic        deq__ENA;
    logic        deq__RDY;
    logic [31:0] first;
    logic        first__RDY;
    logic [2:0]  count;
    logic        err;

    int vectors;
    int miscompares;

    echo_req_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .enq__ENA   (enq__ENA),
        .enq_v      (enq_v),
        .enq__RDY   (enq__RDY),
        .deq__ENA   (deq__ENA),
        .deq__RDY   (deq__RDY),
        .first      (first),
        .first__RDY (first__RDY),
        .count      (count),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] nxt;
        logic [31:0] head;
        logic        err_seen;
        int          sent;
        int          got;
        int          cyc;

        vectors = 0;
        miscompares = 0;
        nRST = 1'b0;
        enq__ENA = 1'b0;
        deq__ENA = 1'b0;
        enq_v = '0;

        // Reset state
        #12;
        check("rst_enq_rdy",   {31'd0, enq__RDY},   32'd0);
        check("rst_deq_rdy",   {31'd0, deq__RDY},   32'd0);
        check("rst_first_rdy", {31'd0, first__RDY}, 32'd0);
        check("rst_count",     {29'd0, count},      32'd0);
        check("rst_err",       {31'd0, err},        32'd0);
        tick();
        nRST = 1'b1;
        #1;
        check("rel_enq_rdy", {31'd0, enq__RDY}, 32'd1);

        // Single word
        tick();
        enq_v = 32'h0000_00A5;
        enq__ENA = 1'b1;
        tick();
        enq__ENA = 1'b0;
        check("one_first_rdy", {31'd0, first__RDY}, 32'd1);
        check("one_first",     first,               32'h0000_00A5);
        check("one_count",     {29'd0, count},      32'd1);
        deq__ENA = 1'b1;
        tick();
        deq__ENA = 1'b0;
        check("one_deq_rdy", {31'd0, first__RDY}, 32'd0);
        check("one_deq_cnt", {29'd0, count},      32'd0);
        check("one_err",     {31'd0, err},        32'd0);

        // Fill to full, overflow attempt, drain
        for (int i = 1; i <= 4; i++) begin
            enq_v = 32'(i);
            enq__ENA = 1'b1;
            tick();
        end
        enq__ENA = 1'b0;
        check("full_count",   {29'd0, count},    32'd4);
        check("full_enq_rdy", {31'd0, enq__RDY}, 32'd0);
        enq_v = 32'd5;
        enq__ENA = 1'b1;
        tick();
        enq__ENA = 1'b0;
        check("ovf_err",   {31'd0, err},   32'd1);
        check("ovf_count", {29'd0, count}, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_first", first, 32'(i));
            deq__ENA = 1'b1;
            tick();
        end
        deq__ENA = 1'b0;
        check("drain_count",   {29'd0, count},    32'd0);
        check("drain_deq_rdy", {31'd0, deq__RDY}, 32'd0);

        // Asynchronous reset with three words queued
        for (int i = 0; i < 3; i++) begin
            enq_v = 32'h30 + 32'(i);
            enq__ENA = 1'b1;
            tick();
        end
        enq__ENA = 1'b0;
        check("pre_arst_count", {29'd0, count}, 32'd3);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_first_rdy", {31'd0, first__RDY}, 32'd0);
        check("arst_count",     {29'd0, count},      32'd0);
        check("arst_err",       {31'd0, err},        32'd0);
        check("arst_enq_rdy",   {31'd0, enq__RDY},   32'd0);
        tick();
        #2;
        nRST = 1'b1;
        #1;
        check("arel_enq_rdy", {31'd0, enq__RDY}, 32'd1);
        tick();
        enq_v = 32'h77;
        enq__ENA = 1'b1;
        tick();
        enq__ENA = 1'b0;
        check("arel_first", first,          32'h77);
        check("arel_count", {29'd0, count}, 32'd1);
        deq__ENA = 1'b1;
        tick();
        deq__ENA = 1'b0;

        // Dequeue on empty
        check("pre_udf_err", {31'd0, err}, 32'd0);
        deq__ENA = 1'b1;
        tick();
        deq__ENA = 1'b0;
        check("udf_count",   {29'd0, count},    32'd0);
        check("udf_err",     {31'd0, err},      32'd1);
        check("udf_deq_rdy", {31'd0, deq__RDY}, 32'd0);
        enq_v = 32'h55;
        enq__ENA = 1'b1;
        tick();
        enq__ENA = 1'b0;
        check("udf_ptr_first", first,          32'h55);
        check("udf_ptr_count", {29'd0, count}, 32'd1);
        deq__ENA = 1'b1;
        tick();
        deq__ENA = 1'b0;

        // Simultaneous enq/deq at count 2, long enough to wrap the pointers twice
        exp_q.delete();
        nxt = 32'h100;
        for (int i = 0; i < 2; i++) begin
            enq_v = nxt;
            exp_q.push_back(nxt);
            nxt++;
            enq__ENA = 1'b1;
            tick();
        end
        check("sim_pre_count", {29'd0, count}, 32'd2);
        for (int i = 0; i < 10; i++) begin
            head = exp_q.pop_front();
            check("sim_first", first, head);
            enq_v = nxt;
            exp_q.push_back(nxt);
            nxt++;
            enq__ENA = 1'b1;
            deq__ENA = 1'b1;
            tick();
            check("sim_count", {29'd0, count}, 32'd2);
        end
        enq__ENA = 1'b0;
        deq__ENA = 1'b0;
        while (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            check("sim_tail", first, head);
            deq__ENA = 1'b1;
            tick();
        end
        deq__ENA = 1'b0;
        check("sim_end_count", {29'd0, count}, 32'd0);

        // Responder-style stream: random gaps, deq whenever ready
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        exp_q.delete();
        sent = 0;
        got = 0;
        cyc = 0;
        err_seen = 1'b0;
        while (got < 100 && cyc < 5000) begin
            enq__ENA = 1'b0;
            deq__ENA = 1'b0;
            if (deq__RDY) begin
                head = exp_q.pop_front();
                check("stream_word", first, head);
                deq__ENA = 1'b1;
                got++;
            end
            if (sent < 100 && enq__RDY && $urandom_range(0, 2) != 0) begin
                enq_v = $urandom();
                exp_q.push_back(enq_v);
                enq__ENA = 1'b1;
                sent++;
            end
            tick();
            err_seen = err_seen | err;
            cyc++;
        end
        enq__ENA = 1'b0;
        deq__ENA = 1'b0;
        check("stream_done", 32'(got), 32'd100);
        check("stream_err",  {31'd0, err_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_echo_req_fifo
